// File: rtl/fmul_pkg.sv
// Shared types and constants for the FMUL result packer.
package fmul_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;

  localparam logic [31:0]         FP_QNAN    = 32'h7FC00000;
  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp_word_t;

  typedef struct packed {
    logic [31:0] data;
    logic        nan;
    logic        ovf;
  } pack_entry_t;

  typedef enum logic [1:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } fp_class_t;

  // First match wins: NaN beats overflow beats zero.
  function automatic fp_class_t classify(input logic err, input logic ovf,
                                         input logic [FP_EXP_W-1:0] ex);
    if (err) return CLS_NAN;
    if (ovf || ex == FP_EXP_MAX) return CLS_INF;
    if (ex == '0) return CLS_ZERO;
    return CLS_NORM;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with simultaneous push/pop; DEPTH must be a power of 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fmul_result_packer.sv
// Rounds, canonicalises and buffers FMUL split-field results as IEEE-754 words.
// Define FMUL_PACK_ROUND_EN for round-half-even; otherwise the fraction is truncated.
module fmul_result_packer
  import fmul_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [7:0]       in_exp,
  input  logic [23:0]      in_frac,
  input  logic             in_error,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_nan,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

  logic        r_s1_valid;
  fp_class_t   r_s1_cls;
  logic        r_s1_sign;
  logic [7:0]  r_s1_exp;
  logic [23:0] r_s1_frac;

  logic [CW-1:0]  w_fifo_count;
  logic [CW:0]    w_occ;
  logic           w_accept;
  logic           w_pop;
  logic           w_fifo_empty;
  logic           w_fifo_full_unused;
  pack_entry_t    w_push_entry;
  pack_entry_t    w_head;
  logic [22:0]    w_mant;
  logic [7:0]     w_exp;
  logic [CNT_W-1:0] r_count;

  // Counting S1 in the occupancy guarantees its FIFO write never finds the FIFO full.
  assign w_occ    = {1'b0, w_fifo_count} + {{CW{1'b0}}, r_s1_valid};
  assign in_ready = !rst && (w_occ < DEPTH_V);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_cls  <= classify(in_error, in_overflow, in_exp);
        r_s1_sign <= in_sign;
        r_s1_exp  <= in_exp;
        r_s1_frac <= in_frac;
      end
    end
  end

`ifdef FMUL_PACK_ROUND_EN
  logic w_inc;
  logic w_carry;
  assign w_inc = r_s1_frac[0] & r_s1_frac[1];
  assign {w_carry, w_mant} = {1'b0, r_s1_frac[23:1]} + {23'b0, w_inc};
  assign w_exp = r_s1_exp + {7'b0, w_carry};
`else
  logic w_unused_round;
  assign w_unused_round = r_s1_frac[0];
  assign w_mant = r_s1_frac[23:1];
  assign w_exp  = r_s1_exp;
`endif

  always_comb begin
    w_push_entry = '0;
    case (r_s1_cls)
      CLS_NAN: begin
        w_push_entry.data = FP_QNAN;
        w_push_entry.nan  = 1'b1;
      end
      CLS_INF: begin
        w_push_entry.data = {r_s1_sign, FP_EXP_MAX, 23'h0};
        w_push_entry.ovf  = 1'b1;
      end
      CLS_ZERO: w_push_entry.data = {r_s1_sign, 31'h0};
      default: begin
        if (w_exp == FP_EXP_MAX) begin
          w_push_entry.data = {r_s1_sign, FP_EXP_MAX, 23'h0};
          w_push_entry.ovf  = 1'b1;
        end else begin
          w_push_entry.data = {r_s1_sign, w_exp, w_mant};
        end
      end
    endcase
  end

  sync_fifo #(
    .WIDTH($bits(pack_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_s1_valid),
    .i_data (w_push_entry),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_fifo_full_unused),
    .o_empty(w_fifo_empty),
    .o_count(w_fifo_count)
  );

  assign out_valid = !rst && !w_fifo_empty;
  assign w_pop     = out_valid && out_ready;
  assign out_data  = w_fifo_empty ? 32'h0 : w_head.data;
  assign out_nan   = !w_fifo_empty && w_head.nan;
  assign out_ovf   = !w_fifo_empty && w_head.ovf;
  assign out_count = r_count;

  always_ff @(posedge clk) begin
    if (rst)        r_count <= '0;
    else if (w_pop) r_count <= r_count + 1'b1;
  end

endmodule
